cl_axi_mon_trig: RTL and testbench
==================================

// Module: cl_axi_mon_trig
// PURPOSE
//  Passive AXI4 handshake monitor that sits between a CL AXI4 bus tap and its debug ILA.
//  Counts outstanding write/read transactions and runs per-direction response watchdogs.
//  Flags response errors and protocol under/overflow.
//  Emits a one-cycle trigger pulse plus sticky status and counters, all wired to ILA probes.
//  Never drives the monitored bus.
// PARAMETERS
//  CNT_W      6     width of outstanding-transaction counters
//  TIMEOUT_W  16    width of watchdog counters
//  TIMEOUT    4096  idle cycles with outstanding>0 before a timeout event (< 2**TIMEOUT_W)
// PORTS
//  aclk        in   1      clock; all inputs sampled on rising edge
//  aresetn     in   1      asynchronous active-low reset
//  awvalid/awready, bvalid/bready, arvalid/arready, rvalid/rready  in 1 each  tapped handshakes
//  rlast       in   1      tapped R last beat
//  bresp       in   2      tapped write response
//  rresp       in   2      tapped read response
//  arm         in   1      pulse: DISARMED/FIRED -> ARMED
//  clear       in   1      pulse: clear sticky status, max counters, go DISARMED
//  evt_en      in   5      per-event trigger enable
//  trig        out  1      one-cycle trigger pulse to ILA trigger input
//  armed       out  1      high in ARMED state
//  evt_sticky  out  5      sticky event flags
//  wr_outst    out  CNT_W  outstanding writes (AW accepted, B not yet accepted)
//  rd_outst    out  CNT_W  outstanding reads (AR accepted, last R not yet accepted)
//  wr_max      out  CNT_W  high-water mark of wr_outst since reset/clear
// BEHAVIOUR
//  Reset: all outputs 0, all counters 0, state DISARMED.
//  Handshakes: aw_hs=awvalid&awready, b_hs=bvalid&bready, ar_hs=arvalid&arready, rl_hs=rvalid&rready&rlast.
//  wr_outst update: +aw_hs, -b_hs; both in the same cycle -> unchanged.
//   - b_hs with count 0 and no aw_hs: count stays 0, underflow.
//   - aw_hs at all-ones without b_hs: count saturates, overflow.
//  rd_outst: same rules with ar_hs / rl_hs.
//  Counters register at cycle t+1 from handshakes at t.
//  wr_max <= max(wr_max, next wr_outst).
//  Watchdog (per direction): wdog resets to 0 when outst==0 or on any progress beat
//   (b_hs for write; any rvalid&rready for read). Otherwise increments, saturating.
//   Timeout event when wdog==TIMEOUT-1 and it increments; fires once, re-fires only after a reset of wdog.
//  Event vector evt_now (combinational from cycle-t inputs/state):
//   [0] b_hs & bresp!=0     [1] rvalid&rready & rresp!=0
//   [2] write timeout       [3] read timeout
//   [4] under/overflow either direction
//  evt_sticky <= evt_sticky | evt_now; cleared only by clear or reset. Counters are not cleared by clear.
//  FSM: DISARMED --arm--> ARMED --(evt_now&evt_en)!=0--> FIRED --arm--> ARMED.
//   trig=1 for exactly the cycle after the ARMED->FIRED transition condition (registered, latency 1).
//   clear has priority over arm; clear in any state -> DISARMED, trig forced 0.
//   arm while ARMED: no effect.
//   arm plus a qualifying event in the same cycle while DISARMED: -> ARMED only, no trigger.
//  Events occurring outside ARMED still set evt_sticky but never pulse trig.
// TESTING
//  1 Reset: assert aresetn=0 mid-traffic -> all outputs 0 immediately; release -> counters start from 0.
//  2 Three aw_hs, then aw_hs+b_hs in one cycle, then three b_hs
//    -> wr_outst 1,2,3,3,2,1,0; wr_max=3; no events.
//  3 arm, evt_en=5'b00001, b_hs with bresp=2'b10
//    -> trig high exactly 1 cycle after; evt_sticky[0]=1; state FIRED, armed=0.
//  4 One ar_hs, no R for TIMEOUT cycles
//    -> evt_sticky[3] set on cycle TIMEOUT; single event;
//    an rvalid&rready beat resets the watchdog.
//  5 b_hs with wr_outst=0 -> wr_outst stays 0, evt_sticky[4]=1;
//    CNT_W=2, four aw_hs -> saturates at 3, overflow flagged.
//  6 arm and clear in the same cycle -> DISARMED, evt_sticky=0;
//    an event while DISARMED -> sticky set, trig stays 0.

Source files
------------

// File: rtl/cl_axi_mon_trig.sv
// Passive AXI4 handshake monitor feeding a debug ILA: outstanding counts, response
// watchdogs, error/under/overflow events and a one-cycle armed trigger pulse.
module cl_axi_mon_trig #(
  parameter int CNT_W     = 6,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             awvalid,
  input  logic             awready,
  input  logic             bvalid,
  input  logic             bready,
  input  logic             arvalid,
  input  logic             arready,
  input  logic             rvalid,
  input  logic             rready,
  input  logic             rlast,
  input  logic [1:0]       bresp,
  input  logic [1:0]       rresp,
  input  logic             arm,
  input  logic             clear,
  input  logic [4:0]       evt_en,
  output logic             trig,
  output logic             armed,
  output logic [4:0]       evt_sticky,
  output logic [CNT_W-1:0] wr_outst,
  output logic [CNT_W-1:0] rd_outst,
  output logic [CNT_W-1:0] wr_max
);

  localparam logic [CNT_W-1:0]     CNT_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] WD_TRIP = TIMEOUT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_DISARMED, ST_ARMED, ST_FIRED} state_t;

  state_t               state;
  logic [TIMEOUT_W-1:0] wr_wdog;
  logic [TIMEOUT_W-1:0] rd_wdog;

  logic aw_hs, b_hs, ar_hs, r_hs, rl_hs;
  logic [CNT_W:0]       wr_step, rd_step;
  logic [TIMEOUT_W:0]   wr_wd_step, rd_wd_step;
  logic [CNT_W-1:0]     wr_nxt, rd_nxt;
  logic                 wr_err, rd_err;
  logic                 wr_trip, rd_trip;
  logic [4:0]           evt_now;
  logic                 hit;

  // Saturating up/down step; MSB of the result flags an under/overflow attempt.
  function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                              input logic inc, input logic dec);
    if (inc && !dec) begin
      if (cnt == CNT_MAX) return {1'b1, cnt};
      return {1'b0, cnt + 1'b1};
    end
    if (dec && !inc) begin
      if (cnt == '0) return {1'b1, cnt};
      return {1'b0, cnt - 1'b1};
    end
    return {1'b0, cnt};
  endfunction

  // Watchdog step; MSB marks the single increment out of WD_TRIP. Saturation at
  // all-ones keeps the count from ever revisiting WD_TRIP without a restart.
  function automatic logic [TIMEOUT_W:0] wdog_step(input logic [TIMEOUT_W-1:0] wd,
                                                   input logic busy, input logic prog);
    if (!busy || prog) return '0;
    if (wd == WD_MAX) return {1'b0, wd};
    return {wd == WD_TRIP, wd + 1'b1};
  endfunction

  always_comb begin
    aw_hs = awvalid & awready;
    b_hs  = bvalid & bready;
    ar_hs = arvalid & arready;
    r_hs  = rvalid & rready;
    rl_hs = r_hs & rlast;

    wr_step    = cnt_step(wr_outst, aw_hs, b_hs);
    rd_step    = cnt_step(rd_outst, ar_hs, rl_hs);
    wr_nxt     = wr_step[CNT_W-1:0];
    rd_nxt     = rd_step[CNT_W-1:0];
    wr_err     = wr_step[CNT_W];
    rd_err     = rd_step[CNT_W];

    wr_wd_step = wdog_step(wr_wdog, wr_outst != '0, b_hs);
    rd_wd_step = wdog_step(rd_wdog, rd_outst != '0, r_hs);
    wr_trip    = wr_wd_step[TIMEOUT_W];
    rd_trip    = rd_wd_step[TIMEOUT_W];

    evt_now    = {wr_err | rd_err, rd_trip, wr_trip, r_hs & (rresp != 2'b00), b_hs & (bresp != 2'b00)};
    hit        = (evt_now & evt_en) != 5'b0;
  end

  // Stage p0 -> registered counters, watchdogs and sticky flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_outst   <= '0;
      rd_outst   <= '0;
      wr_max     <= '0;
      wr_wdog    <= '0;
      rd_wdog    <= '0;
      evt_sticky <= '0;
    end else begin
      wr_outst <= wr_nxt;
      rd_outst <= rd_nxt;
      wr_wdog  <= wr_wd_step[TIMEOUT_W-1:0];
      rd_wdog  <= rd_wd_step[TIMEOUT_W-1:0];
      if (clear) begin
        wr_max     <= '0;
        evt_sticky <= '0;
      end else begin
        wr_max     <= (wr_nxt > wr_max) ? wr_nxt : wr_max;
        evt_sticky <= evt_sticky | evt_now;
      end
    end
  end

  // Stage p0 -> trigger FSM; trig is the registered ARMED->FIRED edge
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_DISARMED;
      trig  <= 1'b0;
    end else if (clear) begin
      state <= ST_DISARMED;
      trig  <= 1'b0;
    end else begin
      trig <= 1'b0;
      case (state)
        ST_DISARMED: if (arm) state <= ST_ARMED;
        ST_ARMED: begin
          if (hit) begin
            state <= ST_FIRED;
            trig  <= 1'b1;
          end
        end
        ST_FIRED:    if (arm) state <= ST_ARMED;
        default:     state <= ST_DISARMED;
      endcase
    end
  end

  assign armed = (state == ST_ARMED);

endmodule

// File: tb/tb_cl_axi_mon_trig.sv
// Directed bench for cl_axi_mon_trig: per-cycle vector table plus reset, watchdog
// and narrow-counter saturation sequences.
module tb_cl_axi_mon_trig;

  localparam int TO = 16;

  logic aclk, aresetn;
  logic awvalid, awready, bvalid, bready, arvalid, arready, rvalid, rready, rlast;
  logic [1:0] bresp, rresp;
  logic arm, clear;
  logic [4:0] evt_en;

  logic       trig, armed;
  logic [4:0] evt_sticky;
  logic [5:0] wr_outst, rd_outst, wr_max;

  logic       trig2, armed2;
  logic [4:0] stk2;
  logic [1:0] wr2, rd2, max2;

  int checks = 0;
  int errors = 0;

  cl_axi_mon_trig #(.CNT_W(6), .TIMEOUT_W(16), .TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .rvalid(rvalid), .rready(rready),
    .rlast(rlast), .bresp(bresp), .rresp(rresp),
    .arm(arm), .clear(clear), .evt_en(evt_en),
    .trig(trig), .armed(armed), .evt_sticky(evt_sticky),
    .wr_outst(wr_outst), .rd_outst(rd_outst), .wr_max(wr_max)
  );

  cl_axi_mon_trig #(.CNT_W(2), .TIMEOUT_W(16), .TIMEOUT(TO)) dut2 (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .rvalid(rvalid), .rready(rready),
    .rlast(rlast), .bresp(bresp), .rresp(rresp),
    .arm(arm), .clear(clear), .evt_en(evt_en),
    .trig(trig2), .armed(armed2), .evt_sticky(stk2),
    .wr_outst(wr2), .rd_outst(rd2), .wr_max(max2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [1:0] aw, b, ar, r;   // {valid, ready}
    logic       rl;
    logic [1:0] bresp, rresp;
    logic       arm, clr;
    logic [4:0] en;
    int         e_wr, e_rd, e_max;
    logic [4:0] e_stk;
    logic       e_trig, e_armed;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic [1:0] aw, logic [1:0] b, logic [1:0] ar, logic [1:0] r,
                              logic rl, logic [1:0] br, logic [1:0] rr, logic a, logic c,
                              logic [4:0] en, int wr, int rd, int mx, logic [4:0] stk,
                              logic tg, logic am);
    vec_t v;
    v.aw = aw; v.b = b; v.ar = ar; v.r = r; v.rl = rl; v.bresp = br; v.rresp = rr;
    v.arm = a; v.clr = c; v.en = en; v.e_wr = wr; v.e_rd = rd; v.e_max = mx;
    v.e_stk = stk; v.e_trig = tg; v.e_armed = am;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    {awvalid, awready, bvalid, bready, arvalid, arready, rvalid, rready, rlast} = '0;
    bresp = 2'b00; rresp = 2'b00; arm = 1'b0; clear = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    {awvalid, awready} = v.aw;
    {bvalid, bready}   = v.b;
    {arvalid, arready} = v.ar;
    {rvalid, rready}   = v.r;
    rlast = v.rl; bresp = v.bresp; rresp = v.rresp;
    arm = v.arm; clear = v.clr; evt_en = v.en;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ntrig;

    //         aw     b      ar     r      rl  bresp  rresp arm clr en        wr rd mx stk       tg am
    vecs[0]  = mk(2'b11,2'b00,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00000, 1,0,1,5'b00000,0,0);
    vecs[1]  = mk(2'b11,2'b00,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00000, 2,0,2,5'b00000,0,0);
    vecs[2]  = mk(2'b10,2'b00,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00000, 2,0,2,5'b00000,0,0);
    vecs[3]  = mk(2'b11,2'b00,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00000, 3,0,3,5'b00000,0,0);
    vecs[4]  = mk(2'b11,2'b11,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00000, 3,0,3,5'b00000,0,0);
    vecs[5]  = mk(2'b00,2'b11,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00000, 2,0,3,5'b00000,0,0);
    vecs[6]  = mk(2'b00,2'b01,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00000, 2,0,3,5'b00000,0,0);
    vecs[7]  = mk(2'b00,2'b11,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00000, 1,0,3,5'b00000,0,0);
    vecs[8]  = mk(2'b00,2'b11,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00000, 0,0,3,5'b00000,0,0);
    vecs[9]  = mk(2'b00,2'b00,2'b00,2'b00,0,2'b00,2'b00,1,0,5'b00001, 0,0,3,5'b00000,0,1);
    vecs[10] = mk(2'b11,2'b00,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00001, 1,0,3,5'b00000,0,1);
    vecs[11] = mk(2'b00,2'b11,2'b00,2'b00,0,2'b10,2'b00,0,0,5'b00001, 0,0,3,5'b00001,1,0);
    vecs[12] = mk(2'b00,2'b00,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00001, 0,0,3,5'b00001,0,0);
    vecs[13] = mk(2'b00,2'b00,2'b00,2'b00,0,2'b00,2'b00,1,1,5'b00001, 0,0,0,5'b00000,0,0);
    vecs[14] = mk(2'b00,2'b11,2'b00,2'b00,0,2'b01,2'b00,0,0,5'b00001, 0,0,0,5'b10001,0,0);
    vecs[15] = mk(2'b00,2'b11,2'b00,2'b00,0,2'b10,2'b00,1,0,5'b00001, 0,0,0,5'b10001,0,1);
    vecs[16] = mk(2'b00,2'b00,2'b00,2'b00,0,2'b00,2'b00,1,0,5'b00001, 0,0,0,5'b10001,0,1);
    vecs[17] = mk(2'b00,2'b00,2'b11,2'b00,0,2'b00,2'b00,0,0,5'b00001, 0,1,0,5'b10001,0,1);
    vecs[18] = mk(2'b00,2'b00,2'b00,2'b11,0,2'b00,2'b00,0,0,5'b00001, 0,1,0,5'b10001,0,1);
    vecs[19] = mk(2'b00,2'b00,2'b00,2'b11,1,2'b00,2'b00,0,0,5'b00001, 0,0,0,5'b10001,0,1);
    vecs[20] = mk(2'b00,2'b00,2'b00,2'b11,1,2'b00,2'b10,0,0,5'b00010, 0,0,0,5'b10011,1,0);
    vecs[21] = mk(2'b00,2'b00,2'b00,2'b00,0,2'b00,2'b00,0,0,5'b00010, 0,0,0,5'b10011,0,0);
    vecs[22] = mk(2'b00,2'b00,2'b00,2'b00,0,2'b00,2'b00,0,1,5'b00000, 0,0,0,5'b00000,0,0);

    idle_inputs();
    evt_en  = 5'b0;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset trig", trig, 0);
    chk("reset armed", armed, 0);
    chk("reset sticky", evt_sticky, 0);
    chk("reset wr_outst", wr_outst, 0);
    chk("reset rd_outst", rd_outst, 0);
    chk("reset wr_max", wr_max, 0);

    // Traffic, then asynchronous reset in the middle of a cycle
    aresetn = 1'b1;
    {awvalid, awready, arvalid, arready} = 4'b1111;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("pre-reset armed", armed, 1);
    step();
    chk("pre-reset wr_outst", wr_outst, 2);
    chk("pre-reset rd_outst", rd_outst, 2);
    #3 aresetn = 1'b0;
    #1;
    chk("async wr_outst", wr_outst, 0);
    chk("async rd_outst", rd_outst, 0);
    chk("async wr_max", wr_max, 0);
    chk("async armed", armed, 0);
    chk("async trig", trig, 0);
    chk("async sticky", evt_sticky, 0);
    chk("async dut2 all", {trig2, armed2, stk2, wr2, rd2, max2}, 0);
    step();
    idle_inputs();
    aresetn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      apply(vecs[i]);
      step();
      chk($sformatf("vec%0d wr_outst", i), wr_outst, vecs[i].e_wr);
      chk($sformatf("vec%0d rd_outst", i), rd_outst, vecs[i].e_rd);
      chk($sformatf("vec%0d wr_max", i), wr_max, vecs[i].e_max);
      chk($sformatf("vec%0d sticky", i), evt_sticky, vecs[i].e_stk);
      chk($sformatf("vec%0d trig", i), trig, vecs[i].e_trig);
      chk($sformatf("vec%0d armed", i), armed, vecs[i].e_armed);
    end
    idle_inputs();

    // Read watchdog: one AR, no R beats
    evt_en = 5'b01000;
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("wd armed", armed, 1);
    {arvalid, arready} = 2'b11;
    step();
    {arvalid, arready} = 2'b00;
    chk("wd rd_outst", rd_outst, 1);
    repeat (TO - 1) step();
    chk("wd early sticky", evt_sticky, 0);
    chk("wd early trig", trig, 0);
    step();
    chk("wd sticky", evt_sticky, 5'b01000);
    chk("wd trig", trig, 1);
    chk("wd fired armed", armed, 0);
    step();
    chk("wd trig pulse", trig, 0);
    arm = 1'b1;
    step();
    arm = 1'b0;
    ntrig = 0;
    repeat (3 * TO) begin
      step();
      if (trig) ntrig++;
    end
    chk("wd single event", ntrig, 0);
    chk("wd still armed", armed, 1);
    {rvalid, rready} = 2'b11;
    step();
    {rvalid, rready} = 2'b00;
    chk("wd beat rd_outst", rd_outst, 1);
    repeat (TO - 1) step();
    chk("wd rearm early trig", trig, 0);
    step();
    chk("wd rearm trig", trig, 1);

    // Narrow counter saturation on dut2
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    idle_inputs();
    evt_en = 5'b0;
    {awvalid, awready} = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("sat%0d dut2 wr_outst", k), wr2, (k > 3) ? 3 : k);
      chk($sformatf("sat%0d dut2 ovf", k), stk2[4], (k > 3) ? 1 : 0);
    end
    idle_inputs();
    chk("sat dut2 wr_max", max2, 3);
    chk("sat dut wr_outst", wr_outst, 4);
    chk("sat dut sticky", evt_sticky, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
